// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB pipeline register and its load aligner.
// Latency: none (types, constants and pure helper functions only).
// Backpressure: not applicable.
package mem_wb_pkg;

  // Write-back source select codes; 2'b11 is legal and selects zero downstream.
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Load width/sign codes carried in funct3.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_wb_load_align.sv
// Load aligner: picks byte/halfword out of a 32-bit memory word and extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module load_align
  import mem_wb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  output logic [31:0] aligned
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Extract the addressed byte and halfword; addr[0] is irrelevant for halfwords.
  always_comb begin
    sel_byte = word[7:0];
    case (addr)
      2'd0: sel_byte = word[7:0];
      2'd1: sel_byte = word[15:8];
      2'd2: sel_byte = word[23:16];
      2'd3: sel_byte = word[31:24];
      default: sel_byte = word[7:0];
    endcase
    sel_half = addr[1] ? word[31:16] : word[15:0];
  end

  // Extend according to load width and signedness; unknown codes pass the word.
  always_comb begin
    aligned = word;
    case (funct3)
      F3_LB:   aligned = sext8(sel_byte);
      F3_LBU:  aligned = {24'b0, sel_byte};
      F3_LH:   aligned = sext16(sel_half);
      F3_LHU:  aligned = {16'b0, sel_half};
      default: aligned = word;
    endcase
  end

endmodule

// File: rtl/mem_wb_reg.sv
// MEM->WB pipeline register with load alignment and optional retire counter (MEM_WB_RETIRE_CNT_EN).
// Latency: 1 cycle from sampled inputs to outputs.
// Backpressure: enable=0 stalls (holds everything); flush inserts a bubble and wins over enable.
module mem_wb_reg
  import mem_wb_pkg::*;
#(
  parameter int size = 32,
  parameter int RD_W = 5
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic            enable,
  input  logic            flush,
  input  logic            valid_in,
  input  logic [size-1:0] alu_result_in,
  input  logic [size-1:0] mem_rdata_in,
  input  logic [size-1:0] pc_plus4_in,
  input  logic [2:0]      funct3_in,
  input  logic [1:0]      wb_sel_in,
  input  logic            reg_write_in,
  input  logic [RD_W-1:0] rd_in,
  output logic [1:0]      wb_sel,
  output logic [size-1:0] alu_result,
  output logic [size-1:0] load_data,
  output logic [size-1:0] pc_plus4,
  output logic            reg_write,
  output logic [RD_W-1:0] rd,
  output logic            valid
`ifdef MEM_WB_RETIRE_CNT_EN
  ,
  output logic [31:0]     retired_count
`endif
);

  logic [size-1:0] aligned;
  logic            capture;

  // A real capture happens only when not flushing.
  assign capture = enable && !flush;

  load_align u_align (
    .word    (mem_rdata_in),
    .funct3  (funct3_in),
    .addr    (alu_result_in[1:0]),
    .aligned (aligned)
  );

  // Control fields: cleared by flush (bubble), loaded on capture, else held.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      valid     <= 1'b0;
      reg_write <= 1'b0;
      wb_sel    <= 2'b00;
      rd        <= '0;
    end else if (flush) begin
      valid     <= 1'b0;
      reg_write <= 1'b0;
      wb_sel    <= 2'b00;
      rd        <= '0;
    end else if (enable) begin
      valid     <= valid_in;
      reg_write <= reg_write_in && valid_in && (rd_in != '0);
      wb_sel    <= wb_sel_in;
      rd        <= rd_in;
    end
  end

  // Data words: only loaded on capture; a flush leaves them as they were.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      alu_result <= '0;
      load_data  <= '0;
      pc_plus4   <= '0;
    end else if (capture) begin
      alu_result <= alu_result_in;
      load_data  <= aligned;
      pc_plus4   <= pc_plus4_in;
    end
  end

`ifdef MEM_WB_RETIRE_CNT_EN
  // Count instructions entering WB; wraps naturally at 2^32.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      retired_count <= 32'd0;
    end else if (capture && valid_in) begin
      retired_count <= retired_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_reg.sv
// Self-checking bench for mem_wb_reg: scoreboard queue fed by stimulus, drained by a monitor.
// Latency: expects outputs one edge after inputs are sampled.
// Backpressure: exercises stall and flush with directed and random patterns.
module tb_mem_wb_reg;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        enable = 1'b0, flush = 1'b0, valid_in = 1'b0;
  logic [31:0] alu_result_in = '0, mem_rdata_in = '0, pc_plus4_in = '0;
  logic [2:0]  funct3_in = '0;
  logic [1:0]  wb_sel_in = '0;
  logic        reg_write_in = 1'b0;
  logic [4:0]  rd_in = '0;
  logic [1:0]  wb_sel;
  logic [31:0] alu_result, load_data, pc_plus4;
  logic        reg_write, valid;
  logic [4:0]  rd;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] retired_count;
`endif

  mem_wb_reg #(.size(32), .RD_W(5)) dut (
    .CLK(CLK), .RST_n(RST_n), .enable(enable), .flush(flush), .valid_in(valid_in),
    .alu_result_in(alu_result_in), .mem_rdata_in(mem_rdata_in), .pc_plus4_in(pc_plus4_in),
    .funct3_in(funct3_in), .wb_sel_in(wb_sel_in), .reg_write_in(reg_write_in), .rd_in(rd_in),
    .wb_sel(wb_sel), .alu_result(alu_result), .load_data(load_data), .pc_plus4(pc_plus4),
    .reg_write(reg_write), .rd(rd), .valid(valid)
`ifdef MEM_WB_RETIRE_CNT_EN
    , .retired_count(retired_count)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  wb_sel;
    logic [31:0] alu, ld, pc, cnt;
    logic        rw, valid;
    logic [4:0]  rd;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load extraction using shifts, masks and signed arithmetic.
  function automatic logic [31:0] ref_align(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] a);
    longint v;
    int     sh;
    case (f3)
      3'd0, 3'd4: begin
        sh = 8 * int'(a);
        v  = longint'((w >> sh) & 32'hFF);
        if (f3 == 3'd0 && v >= 128) v = v - 256;
        return 32'(v);
      end
      3'd1, 3'd5: begin
        sh = (int'(a) / 2) * 16;
        v  = longint'((w >> sh) & 32'hFFFF);
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
        return 32'(v);
      end
      default: return w;
    endcase
  endfunction

  function automatic exp_t zero_state();
    exp_t z;
    z.wb_sel = '0; z.alu = '0; z.ld = '0; z.pc = '0; z.cnt = '0;
    z.rw = 1'b0; z.valid = 1'b0; z.rd = '0;
    return z;
  endfunction

  // Drive one cycle of inputs at the falling edge and predict the state after the next rising edge.
  task automatic cyc(input logic en, input logic fl, input logic v, input logic [31:0] alu,
                     input logic [31:0] mem, input logic [31:0] pc, input logic [2:0] f3,
                     input logic [1:0] sel, input logic rw, input logic [4:0] d);
    @(negedge CLK);
    enable = en; flush = fl; valid_in = v; alu_result_in = alu; mem_rdata_in = mem;
    pc_plus4_in = pc; funct3_in = f3; wb_sel_in = sel; reg_write_in = rw; rd_in = d;
    if (fl) begin
      m.valid = 1'b0; m.rw = 1'b0; m.wb_sel = 2'b00; m.rd = '0;
    end else if (en) begin
      m.alu = alu; m.pc = pc; m.ld = ref_align(mem, f3, alu[1:0]);
      m.wb_sel = sel; m.rd = d; m.valid = v;
      m.rw = rw && v && (d != 0);
      if (v) m.cnt = m.cnt + 1;
    end
    q.push_back(m);
  endtask

  task automatic settle();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wb_sel"}, wb_sel, 0);
    chk({tag, "_alu"}, alu_result, 0);
    chk({tag, "_ld"}, load_data, 0);
    chk({tag, "_pc"}, pc_plus4, 0);
    chk({tag, "_rw"}, reg_write, 0);
    chk({tag, "_rd"}, rd, 0);
    chk({tag, "_valid"}, valid, 0);
`ifdef MEM_WB_RETIRE_CNT_EN
    chk({tag, "_cnt"}, retired_count, 0);
`endif
  endtask

  task automatic idle_inputs();
    enable = 1'b0; flush = 1'b0; valid_in = 1'b0; reg_write_in = 1'b0;
  endtask

  // Monitor: the register presents a new state every edge; compare against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("mon_wb_sel", wb_sel, e.wb_sel);
        chk("mon_alu", alu_result, e.alu);
        chk("mon_load_data", load_data, e.ld);
        chk("mon_pc4", pc_plus4, e.pc);
        chk("mon_reg_write", reg_write, e.rw);
        chk("mon_rd", rd, e.rd);
        chk("mon_valid", valid, e.valid);
`ifdef MEM_WB_RETIRE_CNT_EN
        chk("mon_cnt", retired_count, e.cnt);
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    m = zero_state();
    // Reset held with busy, nonzero inputs: outputs must stay zero across edges.
    enable = 1'b1; valid_in = 1'b1; alu_result_in = 32'hDEAD_BEEF; mem_rdata_in = 32'hFFFF_FFFF;
    pc_plus4_in = 32'h1234_5678; wb_sel_in = 2'b10; reg_write_in = 1'b1; rd_in = 5'd9;
    repeat (3) @(posedge CLK);
    #1;
    chk_all_zero("reset");
    idle_inputs();
    @(negedge CLK);
    RST_n = 1'b1;

    // First capture after reset.
    cyc(1, 0, 1, 32'h10, 32'h0, 32'h4, 3'd2, 2'b00, 1, 5'd5);
    settle();
    chk("first_alu", alu_result, 32'h10);
    chk("first_rd", rd, 5);
    chk("first_rw", reg_write, 1);
    chk("first_valid", valid, 1);

    // Load extension patterns on a fixed memory word.
    cyc(1, 0, 1, 32'h100, 32'h8A7F_C381, 32'h8, 3'b000, 2'b01, 1, 5'd1); settle();
    chk("lb_a0", load_data, 32'hFFFF_FF81);
    cyc(1, 0, 1, 32'h101, 32'h8A7F_C381, 32'h8, 3'b100, 2'b01, 1, 5'd1); settle();
    chk("lbu_a1", load_data, 32'h0000_00C3);
    cyc(1, 0, 1, 32'h102, 32'h8A7F_C381, 32'h8, 3'b001, 2'b01, 1, 5'd1); settle();
    chk("lh_a2", load_data, 32'hFFFF_8A7F);
    cyc(1, 0, 1, 32'h102, 32'h8A7F_C381, 32'h8, 3'b101, 2'b01, 1, 5'd1); settle();
    chk("lhu_a2", load_data, 32'h0000_8A7F);
    cyc(1, 0, 1, 32'h100, 32'h8A7F_C381, 32'h8, 3'b010, 2'b01, 1, 5'd1); settle();
    chk("lw", load_data, 32'h8A7F_C381);
    cyc(1, 0, 1, 32'h103, 32'h8A7F_C381, 32'h8, 3'b001, 2'b11, 1, 5'd2); settle();
    chk("lh_a3_ignores_a0", load_data, 32'hFFFF_8A7F);
    chk("wb_sel_11_kept", wb_sel, 2'b11);

    // Capture, stall three edges with changing inputs, then flush while enable is high.
    cyc(1, 0, 1, 32'h55, 32'h1234, 32'h200, 3'b010, 2'b01, 1, 5'd7);
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 1, $urandom, $urandom, $urandom, 3'(i), 2'b10, 1, 5'd30);
    settle();
    chk("stall_rd", rd, 7);
    chk("stall_alu", alu_result, 32'h55);
    cyc(1, 1, 1, 32'h999, 32'h777, 32'h333, 3'b010, 2'b10, 1, 5'd12); settle();
    chk("flush_valid", valid, 0);
    chk("flush_rw", reg_write, 0);
    chk("flush_rd", rd, 0);
    chk("flush_wb_sel", wb_sel, 0);
    chk("flush_alu_held", alu_result, 32'h55);
    chk("flush_ld_held", load_data, 32'h1234);
    chk("flush_pc_held", pc_plus4, 32'h200);

    // Writes to x0 and from invalid slots are suppressed.
    cyc(1, 0, 1, 32'h20, 32'h0, 32'h24, 3'b010, 2'b00, 1, 5'd0); settle();
    chk("x0_rw", reg_write, 0);
    chk("x0_valid", valid, 1);
    cyc(1, 0, 0, 32'h30, 32'h0, 32'h34, 3'b010, 2'b00, 1, 5'd3); settle();
    chk("inv_rw", reg_write, 0);
    chk("inv_valid", valid, 0);
    chk("inv_rd", rd, 3);

    // Load some state, then assert reset between edges and check without waiting for a clock.
    cyc(1, 0, 1, 32'hABCD, 32'h5555, 32'h44, 3'b000, 2'b01, 1, 5'd4);
    settle();
    #1;
    RST_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    m = zero_state();
    idle_inputs();
    @(negedge CLK);
    RST_n = 1'b1;

`ifdef MEM_WB_RETIRE_CNT_EN
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 32'(i), 32'h0, 32'h0, 3'b010, 2'b00, 1, 5'd1);
    cyc(0, 0, 1, 32'h0, 32'h0, 32'h0, 3'b010, 2'b00, 1, 5'd1);
    cyc(1, 1, 1, 32'h0, 32'h0, 32'h0, 3'b010, 2'b00, 1, 5'd1);
    settle();
    chk("cnt_four", retired_count, 4);
    force dut.retired_count = 32'hFFFF_FFFF;
    #1;
    release dut.retired_count;
    m.cnt = 32'hFFFF_FFFF;
    cyc(1, 0, 1, 32'h0, 32'h0, 32'h0, 3'b010, 2'b00, 1, 5'd1); settle();
    chk("cnt_wrap", retired_count, 0);
`endif

    // Randomized traffic, biased toward x0 destinations and occasional stall/flush.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] d;
      d = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, 1'($urandom), $urandom,
          $urandom, $urandom, 3'($urandom), 2'($urandom), 1'($urandom), d);
    end
    idle_inputs();
    repeat (3) @(posedge CLK);
    #2;
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_reg.md
Name: mem_wb_reg

Overview:
Pipeline register between the memory-access stage and the write-back stage of the processor core.
- Captures the ALU result, load data and PC+4 of the instruction leaving MEM.
- Aligns and sign- or zero-extends load data before registering it.
- Presents the three registered data words and the 2-bit select directly to the write-back 4-to-1 selector, plus the register-file write controls.
- Supports stall (hold) and flush (bubble insertion).

Parameters:
- size, 32, datapath width in bits. Only 32 is supported by the load aligner.
- RD_W, 5, destination-register index width.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_n  input  1  asynchronous active-low reset.
- enable  input  1  1 = capture on this edge; 0 = stall, hold all state.
- flush  input  1  1 = insert a bubble on this edge; has priority over enable.
- valid_in  input  1  MEM stage holds a real instruction.
- alu_result_in  input  size  ALU result, which is also the memory address.
- mem_rdata_in  input  size  raw 32-bit word read from data memory.
- pc_plus4_in  input  size  PC+4 of the instruction.
- funct3_in  input  3  load width/sign code.
- wb_sel_in  input  2  write-back source select.
- reg_write_in  input  1  instruction writes the register file.
- rd_in  input  RD_W  destination register index.
- wb_sel  output  2  registered select; drives selector `select`.
- alu_result  output  size  registered ALU result; drives selector input 1.
- load_data  output  size  registered aligned/extended load data; drives selector input 2.
- pc_plus4  output  size  registered PC+4; drives selector input 3.
- reg_write  output  1  registered register-file write enable.
- rd  output  RD_W  registered destination index.
- valid  output  1  WB stage holds a real instruction.

Behaviour:
- Reset (RST_n=0, asynchronous): every output is 0 immediately and stays 0 until the first rising edge after RST_n returns high.
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Priority at each rising edge: flush > enable.
- flush=1:
  - valid, reg_write, wb_sel and rd are cleared to 0.
  - alu_result, load_data and pc_plus4 hold their previous values.
  - enable is ignored.
- flush=0, enable=0: all outputs hold (stall).
- flush=0, enable=1: all fields load from their inputs, except reg_write and load_data:
  - reg_write loads reg_write_in & valid_in & (rd_in != 0). Writes to x0 are suppressed.
  - load_data loads the aligned value defined below.
- Load alignment is combinational before the register, using a = alu_result_in[1:0]:
  - funct3 000 (LB): byte a of mem_rdata_in, sign-extended.
  - funct3 100 (LBU): byte a, zero-extended.
  - funct3 001 (LH): halfword a[1], sign-extended. a[0] is ignored.
  - funct3 101 (LHU): halfword a[1], zero-extended. a[0] is ignored.
  - funct3 010 (LW) and every other code: mem_rdata_in unchanged.
  - Byte 0 = bits [7:0]. Halfword 0 = bits [15:0].
  - Alignment is applied regardless of wb_sel_in.
- wb_sel_in=11 is registered unchanged. The downstream selector outputs 0 for it.
- A reset deasserted mid-operation needs no special recovery. The first captured instruction is the first edge with enable=1 and flush=0.

Optional Feature:
- Macro: MEM_WB_RETIRE_CNT_EN.
- Defined:
  - Adds output retired_count, 32 bits, reset to 0.
  - Increments by 1 on every edge with enable=1, flush=0 and valid_in=1.
  - Wraps from 0xFFFFFFFF to 0.
  - Holds on stall and flush.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Decomposition:
- Shared package mem_wb_pkg:
  - WB_ALU=2'b00, WB_MEM=2'b01, WB_PC4=2'b10.
  - F3_LB=3'b000, F3_LH=3'b001, F3_LW=3'b010, F3_LBU=3'b100, F3_LHU=3'b101.
- Natural sub-module: load_align, combinational, 32-bit. Inputs are word, funct3 and addr[1:0]; output is the aligned word. It can be reused by a future forwarding path.

Test Plan:
- Reset: hold RST_n=0 while inputs are nonzero -> all outputs 0. Then release RST_n, apply enable=1, valid_in=1, alu_result_in=0x00000010, wb_sel_in=00, rd_in=5, reg_write_in=1 -> after 1 edge: alu_result=0x10, rd=5, reg_write=1, valid=1.
- Load extension: mem_rdata_in=0x8A7F_C381.
  - LB, a=0 -> load_data=0xFFFFFF81.
  - LBU, a=1 -> load_data=0x000000C3.
  - LH, a=2 -> load_data=0xFFFF8A7F.
  - LHU, a=2 -> load_data=0x00008A7F.
  - LW -> load_data=0x8A7FC381.
- Stall then flush: capture rd=7, then enable=0 for 3 edges -> outputs unchanged. Then flush=1 with enable=1 -> valid=0, reg_write=0, rd=0, wb_sel=0, while alu_result, load_data and pc_plus4 keep their old values.
- x0 and invalid suppression: rd_in=0 with reg_write_in=1 -> reg_write=0. Then rd_in=3, reg_write_in=1, valid_in=0 -> reg_write=0, valid=0.
- Asynchronous reset mid-stream: drive RST_n=0 between clock edges -> outputs 0 without waiting for an edge.
- With MEM_WB_RETIRE_CNT_EN defined:
  - 4 valid captures, 1 stall and 1 flush -> retired_count=4.
  - Preload the counter with 0xFFFFFFFF by force, then 1 valid capture -> retired_count=0.
